// File: rtl/sync_fifo_status_pkg.sv
// Shared defaults and helpers for the FIFO occupancy/flag generator.
// The optional error outputs are enabled by defining SYNC_FIFO_STATUS_ERR_EN.
package sync_fifo_status_pkg;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_AF_OFFSET  = 2;
  localparam int DEF_AE_LEVEL   = 2;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_status_if.sv
// Strobe/flag bundle between the FIFO controllers and the status block.
// overflow_err/underflow_err exist only when SYNC_FIFO_STATUS_ERR_EN is defined.
interface sync_fifo_status_if #(
  parameter int CNT_W = 5
);

  logic             wr_en;
  logic             rd_en;
  logic             wr_full;
  logic             rd_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] fifo_count;
`ifdef SYNC_FIFO_STATUS_ERR_EN
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output wr_en, rd_en,
    input  wr_full, rd_empty, almost_full, almost_empty, fifo_count,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, rd_en,
    output wr_full, rd_empty, almost_full, almost_empty, fifo_count,
    output overflow_err, underflow_err
  );
`else
  modport master (
    output wr_en, rd_en,
    input  wr_full, rd_empty, almost_full, almost_empty, fifo_count
  );

  modport slave (
    input  wr_en, rd_en,
    output wr_full, rd_empty, almost_full, almost_empty, fifo_count
  );
`endif

endinterface

// File: rtl/sync_fifo_status.sv
// Occupancy counter and registered full/empty/almost flags for the synchronous FIFO.
// Define SYNC_FIFO_STATUS_ERR_EN to add sticky overflow_err/underflow_err outputs.
module sync_fifo_status
  import sync_fifo_status_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int AF_LEVEL   = MEM_DEPTH - DEF_AF_OFFSET,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              reset_n,
  sync_fifo_status_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_full_q, wr_full_d;
  logic             rd_empty_q, rd_empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             wr_ok, rd_ok;

  // Saturate against misbehaving upstreams so the count can never wrap.
  assign wr_ok = bus.wr_en & (count_q != FULL_CNT);
  assign rd_ok = bus.rd_en & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + ONE_CNT;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - ONE_CNT;
    end
    wr_full_d      = (count_d == FULL_CNT);
    rd_empty_d     = (count_d == '0);
    almost_full_d  = (count_d >= AF_CNT);
    almost_empty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      count_q        <= count_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.fifo_count   = count_q;
  assign bus.wr_full      = wr_full_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;

`ifdef SYNC_FIFO_STATUS_ERR_EN
  logic overflow_err_q, overflow_err_d;
  logic underflow_err_q, underflow_err_d;

  // Sticky: only reset_n clears these.
  always_comb begin
    overflow_err_d  = overflow_err_q  | (bus.wr_en & (count_q == FULL_CNT));
    underflow_err_d = underflow_err_q | (bus.rd_en & (count_q == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign bus.overflow_err  = overflow_err_q;
  assign bus.underflow_err = underflow_err_q;
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// Directed self-checking bench for sync_fifo_status (depth 16, AF 14, AE 2).
// Error-flag checks are active when SYNC_FIFO_STATUS_ERR_EN is defined.
module tb_sync_fifo_status;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sync_fifo_status_if #(.CNT_W(CW)) bus_if ();

  sync_fifo_status #(
    .MEM_DEPTH (DEPTH),
    .ADDR_WIDTH(4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive strobes for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r);
    bus_if.wr_en = w;
    bus_if.rd_en = r;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic full, input logic empty,
                         input logic af, input logic ae);
    chk({tag, ".count"}, 32'(bus_if.fifo_count), 32'(cnt));
    chk({tag, ".full"},  32'(bus_if.wr_full), 32'(full));
    chk({tag, ".empty"}, 32'(bus_if.rd_empty), 32'(empty));
    chk({tag, ".af"},    32'(bus_if.almost_full), 32'(af));
    chk({tag, ".ae"},    32'(bus_if.almost_empty), 32'(ae));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SYNC_FIFO_STATUS_ERR_EN
    chk("reset.ovf", 32'(bus_if.overflow_err), 32'd0);
    chk("reset.unf", 32'(bus_if.underflow_err), 32'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill from empty: flags follow the new count in the cycle after each write.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0);
      chk_all($sformatf("fill%0d", i), i, (i == DEPTH), 1'b0, (i >= 14), (i <= 2));
    end

    step(1'b1, 1'b1);
    chk_all("full_wr_rd", 15, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_all("refill", 16, 1'b1, 1'b0, 1'b1, 1'b0);

    step(1'b1, 1'b0);
    chk_all("ovf_write", 16, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_STATUS_ERR_EN
    chk("ovf.set", 32'(bus_if.overflow_err), 32'd1);
    chk("ovf.unf_clear", 32'(bus_if.underflow_err), 32'd0);
`endif

    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1);
      chk_all($sformatf("drain%0d", i), DEPTH - i, 1'b0, (i == DEPTH), (DEPTH - i >= 14),
              (DEPTH - i <= 2));
    end

    step(1'b0, 1'b1);
    chk_all("unf_read", 0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SYNC_FIFO_STATUS_ERR_EN
    chk("unf.set", 32'(bus_if.underflow_err), 32'd1);
    chk("ovf.sticky", 32'(bus_if.overflow_err), 32'd1);
`endif

    step(1'b1, 1'b1);
    chk_all("empty_wr_rd", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0);
    chk_all("mid8", 8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      chk_all($sformatf("hold%0d", i), 8, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`ifdef SYNC_FIFO_STATUS_ERR_EN
    chk("unf.sticky", 32'(bus_if.underflow_err), 32'd1);
`endif

    step(1'b1, 1'b0);
    chk_all("pre_reset9", 9, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges; writes presented while in reset are dropped.
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SYNC_FIFO_STATUS_ERR_EN
    chk("rst.ovf", 32'(bus_if.overflow_err), 32'd0);
    chk("rst.unf", 32'(bus_if.underflow_err), 32'd0);
`endif
    step(1'b1, 1'b0);
    chk_all("rst_write_dropped", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    reset_n = 1'b1;
    #2;

    step(1'b1, 1'b0);
    chk_all("post_rst_wr", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_all("post_rst_rd", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_status.md
Name: sync_fifo_status

Overview:
- Occupancy and flag generator for the synchronous FIFO.
- Sits directly downstream of the write-side controller and the read-side controller.
- Consumes their qualified strobes (wr_en, rd_en) and produces the registered wr_full / rd_empty flags they gate on, plus programmable almost-full/almost-empty and an occupancy count.
- Flags are computed from next-state occupancy, so they are correct in the cycle immediately after the access that changes them. This gives zero-bubble, no-overflow operation.

Parameters:
- MEM_DEPTH, `FIFO_DEPTH, number of FIFO entries; any value >= 2, power of two not required.
- ADDR_WIDTH, $clog2(MEM_DEPTH), pointer width; the count is ADDR_WIDTH+1 bits.
- AF_LEVEL, MEM_DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..MEM_DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..MEM_DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- wr_en  input  1  accepted write this cycle (from write control).
- rd_en  input  1  accepted read this cycle (from read control).
- wr_full  output  1  FIFO full; registered.
- rd_empty  output  1  FIFO empty; registered.
- almost_full  output  1  count >= AF_LEVEL; registered.
- almost_empty  output  1  count <= AE_LEVEL; registered.
- fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..MEM_DEPTH; registered.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on reset_n; all state is cleared immediately on assertion and released synchronously on the next clk edge.
- Reset values: fifo_count=0, rd_empty=1, wr_full=0, almost_empty=1 (AE_LEVEL >= 0), almost_full=0 (AF_LEVEL >= 1).
- Effective strobes:
  - wr_ok = wr_en & (fifo_count != MEM_DEPTH)
  - rd_ok = rd_en & (fifo_count != 0)
  - These are defensive saturation; legal upstreams never drive wr_en while full or rd_en while empty.
- count_next:
  - +1 when wr_ok and not rd_ok.
  - -1 when rd_ok and not wr_ok.
  - Unchanged when both or neither are set.
  - Arithmetic is unsigned, ADDR_WIDTH+1 bits, never wraps.
- Register update on every posedge clk:
  - fifo_count <= count_next
  - wr_full <= (count_next == MEM_DEPTH)
  - rd_empty <= (count_next == 0)
  - almost_full <= (count_next >= AF_LEVEL)
  - almost_empty <= (count_next <= AE_LEVEL)
- Latency: every output reflects an access one cycle after the wr_en/rd_en edge. There is no additional lag, so the write controller sees wr_full in the first cycle where a further write would overflow.
- Boundary conditions:
  - Simultaneous wr_en and rd_en at count 1..MEM_DEPTH-1: count and all flags hold.
  - Simultaneous wr_en and rd_en when empty: write only, count -> 1.
  - Simultaneous wr_en and rd_en when full: read only, count -> MEM_DEPTH-1.
  - Full and empty are mutually exclusive at all times.
  - almost_full and almost_empty may both be high if thresholds overlap; this is legal.
- Reset mid-operation: all outputs return to reset values asynchronously. Any access in the reset cycle is discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SYNC_FIFO_STATUS_ERR_EN.
- When defined:
  - Adds outputs overflow_err and underflow_err (1 bit each, sticky, reset 0).
  - overflow_err sets on any clk where wr_en=1 and fifo_count==MEM_DEPTH.
  - underflow_err sets on any clk where rd_en=1 and fifo_count==0.
  - Both clear only via reset_n.
- When undefined: ports and logic are absent; saturation behaviour is unchanged.

Decomposition:
- sync_fifo_defines.vh holds FIFO_DEPTH, default AF/AE offsets and the SYNC_FIFO_STATUS_ERR_EN switch.
- No sub-module: threshold compares are inline.
- Top-level sync_fifo instantiates write control, read control, memory and sync_fifo_status side by side.

Test Plan (MEM_DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
- Reset with reset_n=0 mid-stream at count 9 -> same-cycle fifo_count=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0.
- 16 back-to-back wr_en from empty -> count 1..16. rd_empty falls after the first write. almost_empty falls at count 3. almost_full rises at count 14. wr_full rises the cycle after write 16.
- Full, then wr_en=1 and rd_en=1 together -> count 15, wr_full=0. A further wr_en alone -> count 16, wr_full=1.
- Count 8, wr_en and rd_en both held for 20 cycles -> count stays 8, no flag toggles.
- Drain 16 reads from full -> rd_empty=1 after the 16th read. An extra rd_en leaves count 0. With SYNC_FIFO_STATUS_ERR_EN, underflow_err=1 and stays set.
- Illegal wr_en at full with SYNC_FIFO_STATUS_ERR_EN -> count stays 16, overflow_err=1 until reset_n asserted.
